// File: rtl/channel_wrap_pkg.sv
// Shared constants for the channel wrap tester: line map, pattern indices and FSM states.
package channel_wrap_pkg;

    // Wrapped line map: bus 0..7, bus parity, mark 0, then the nine tag lines.
    localparam int unsigned BUS_LSB    = 0;
    localparam int unsigned BUS_MSB    = BUS_LSB + 7;
    localparam int unsigned BUS_PARITY = BUS_MSB + 1;
    localparam int unsigned MARK0      = BUS_PARITY + 1;
    localparam int unsigned TAG_LSB    = MARK0 + 1;
    localparam int unsigned TAG_MSB    = TAG_LSB + 8;

    localparam int unsigned WRAP_LINES    = TAG_MSB + 1;
    localparam int unsigned PATTERN_COUNT = 40;
    localparam int unsigned PAT_W         = 6;

    localparam logic [PAT_W-1:0] PAT_ONES   = PAT_W'(1);
    localparam logic [PAT_W-1:0] WALK1_BASE = PAT_W'(2);
    localparam logic [PAT_W-1:0] WALK0_BASE = PAT_W'(2 + WRAP_LINES);
    localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(PATTERN_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/channel_wrap_tester_pattern_gen.sv
// Combinational pattern table: index 0 all-zero, 1 all-one, then walking one, then walking zero.
module wrap_pattern_gen
    import channel_wrap_pkg::*;
(
    input  logic [PAT_W-1:0]      idx_i,
    output logic [WRAP_LINES-1:0] pattern_o
);

    localparam logic [WRAP_LINES-1:0] ONE_HOT_BASE = WRAP_LINES'(1);

    logic [PAT_W-1:0] bit_sel;

    always_comb begin
        bit_sel   = '0;
        pattern_o = '0;
        if (idx_i == PAT_ONES) begin
            pattern_o = '1;
        end else if (idx_i >= WALK1_BASE && idx_i < WALK0_BASE) begin
            bit_sel   = idx_i - WALK1_BASE;
            pattern_o = ONE_HOT_BASE << bit_sel;
        end else if (idx_i >= WALK0_BASE && idx_i <= PAT_LAST) begin
            bit_sel   = idx_i - WALK0_BASE;
            pattern_o = ~(ONE_HOT_BASE << bit_sel);
        end
    end

endmodule

// File: rtl/channel_wrap_tester.sv
// Self-running wrap tester for one bus-and-tag channel. First-fail capture is built only when
// WRAP_TEST_FIRST_FAIL_EN is defined; otherwise fail_index_o/fail_data_o are tied to zero.
module channel_wrap_tester
    import channel_wrap_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_W-1:0]      err_count_o,
    output logic                  frontend_enable_o,
    output logic [WRAP_LINES-1:0] wrap_out_o,
    input  logic [WRAP_LINES-1:0] wrap_in_i,
    output logic [PAT_W-1:0]      fail_index_o,
    output logic [WRAP_LINES-1:0] fail_data_o
);

    state_e                state_q, state_d;
    logic [PAT_W-1:0]      pat_q, pat_d;
    logic [7:0]            settle_q, settle_d;
    logic [7:0]            sweep_q, sweep_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic                  pass_q, pass_d;
    logic [WRAP_LINES-1:0] wrap_q, wrap_d;
    logic [WRAP_LINES-1:0] sync1_q, sync2_q;
    logic [WRAP_LINES-1:0] pattern;
    logic                  busy, abort_hit, start_accept, check_fire, mismatch;

    wrap_pattern_gen u_pattern_gen (
        .idx_i     (pat_q),
        .pattern_o (pattern)
    );

    assign busy         = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
    assign abort_hit    = abort_i && busy;
    assign start_accept = (state_q == StIdle) && start_i && !abort_i;
    assign check_fire   = (state_q == StCheck) && !abort_i;
    assign mismatch     = sync2_q != pattern;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        settle_d = settle_q;
        sweep_d  = sweep_q;
        err_d    = err_q;
        pass_d   = pass_q;
        wrap_d   = wrap_q;
        unique case (state_q)
            StIdle: begin
                if (start_accept) begin
                    state_d = StDrive;
                    pat_d   = '0;
                    sweep_d = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            StDrive: begin
                wrap_d   = pattern;
                settle_d = 8'(SETTLE_CYCLES);
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == 8'd1) state_d = StCheck;
                else                  settle_d = settle_q - 8'd1;
            end
            StCheck: begin
                if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
                if (pat_q == PAT_LAST) begin
                    pat_d   = '0;
                    sweep_d = sweep_q + 8'd1;
                    state_d = (sweep_q == 8'(PASSES - 1)) ? StDone : StDrive;
                end else begin
                    pat_d   = pat_q + PAT_W'(1);
                    state_d = StDrive;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort wins over any in-flight step; the mismatch count is frozen where it stands.
        if (abort_hit) begin
            state_d = StDone;
            err_d   = err_q;
        end
        if (state_d == StDone && state_q != StDone) begin
            pass_d = !abort_hit && (err_d == '0);
            wrap_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            settle_q <= '0;
            sweep_q  <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            wrap_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            settle_q <= settle_d;
            sweep_q  <= sweep_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            wrap_q   <= wrap_d;
            sync1_q  <= wrap_in_i;
            sync2_q  <= sync1_q;
        end
    end

`ifdef WRAP_TEST_FIRST_FAIL_EN
    logic [PAT_W-1:0]      fail_idx_q, fail_idx_d;
    logic [WRAP_LINES-1:0] fail_data_q, fail_data_d;

    // A zero error count at a mismatching check means this is the run's first failure.
    always_comb begin
        fail_idx_d  = fail_idx_q;
        fail_data_d = fail_data_q;
        if (start_accept) begin
            fail_idx_d  = '0;
            fail_data_d = '0;
        end else if (check_fire && mismatch && (err_q == '0)) begin
            fail_idx_d  = pat_q;
            fail_data_d = sync2_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fail_idx_q  <= '0;
            fail_data_q <= '0;
        end else begin
            fail_idx_q  <= fail_idx_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign fail_index_o = fail_idx_q;
    assign fail_data_o  = fail_data_q;
`else
    logic unused_capture;
    assign unused_capture = start_accept ^ check_fire;
    assign fail_index_o   = '0;
    assign fail_data_o    = '0;
`endif

    assign busy_o            = busy;
    assign done_o            = (state_q == StDone);
    assign pass_o            = pass_q;
    assign err_count_o       = err_q;
    assign frontend_enable_o = busy;
    assign wrap_out_o        = wrap_q;

endmodule
